// File: rtl/switch_cfg_pkg.sv
// Shared types for the switch configuration sequencer: FSM states, error
// codes and the 8-bit port address type.
package switch_cfg_pkg;

   localparam int NUM_PORTS = 4;

   typedef logic [7:0] port_addr_t;

   typedef enum logic [2:0] {
      IDLE,
      CHECK,
      WRITE,
      READ,
      WAIT,
      DONE,
      ERR
   } cfg_state_t;

   typedef enum logic [1:0] {
      ERR_NONE     = 2'd0,
      ERR_DUP      = 2'd1,
      ERR_MISMATCH = 2'd2
   } cfg_err_t;

endpackage

// File: rtl/switch_cfg_ctrl_if.sv
// Port-address memory bus of the packet switch; the sequencer is the master.
interface switch_cfg_ctrl_if;
   import switch_cfg_pkg::*;

   logic       mem_en;
   logic       mem_rd_wr;
   logic [1:0] mem_add;
   port_addr_t mem_data;
   port_addr_t mem_rdata;

   modport master (output mem_en, output mem_rd_wr, output mem_add,
                   output mem_data, input mem_rdata);
   modport slave  (input mem_en, input mem_rd_wr, input mem_add,
                   input mem_data, output mem_rdata);

endinterface

// File: rtl/cfg_dup_check.sv
// Pairwise equality check of the four port addresses; reports the higher
// index of the first equal pair in scan order (0,1),(0,2),(0,3),(1,2),(1,3),(2,3).
module cfg_dup_check
   import switch_cfg_pkg::*;
(
   input  port_addr_t [NUM_PORTS-1:0] addr,
   output logic                       dup,
   output logic [1:0]                 dup_port
);

   // NOTE: both outputs get a default before the loops so no path through
   // the block leaves them unassigned, which would infer a latch.
   always_comb begin
      dup      = 1'b0;
      dup_port = 2'd0;
      for (int i = 0; i < NUM_PORTS - 1; i++) begin
         for (int j = i + 1; j < NUM_PORTS; j++) begin
            if (!dup && addr[i] == addr[j]) begin
               dup      = 1'b1;
               dup_port = j[1:0];
            end
         end
      end
   end

endmodule

// File: rtl/switch_cfg_ctrl.sv
// Configuration sequencer: checks, writes and reads back the four switch port
// addresses, then raises cfg_valid to allow packet injection.
module switch_cfg_ctrl
   import switch_cfg_pkg::*;
#(
   parameter int RD_LAT = 1
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic [31:0]       addr_cfg,
   switch_cfg_ctrl_if.master mem,
   output logic              busy,
   output logic              done,
   output logic              cfg_valid,
   output logic              error,
   output logic [1:0]        err_code,
   output logic [1:0]        err_port
);

   cfg_state_t                   state, next_state;
   logic [1:0]                   idx;
   logic [2:0]                   lat_cnt;
   port_addr_t [NUM_PORTS-1:0]   shadow;
   logic                         dup;
   logic [1:0]                   dup_port;
   logic                         rd_ok;

   cfg_dup_check u_dup_check (
      .addr     (shadow),
      .dup      (dup),
      .dup_port (dup_port)
   );

   assign rd_ok = (mem.mem_rdata == shadow[idx]);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values, independent of block ordering.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:  if (start) next_state = CHECK;
         CHECK: next_state = dup ? ERR : WRITE;
         WRITE: if (idx == 2'd3) next_state = READ;
         READ:  next_state = WAIT;
         WAIT: begin
            if (lat_cnt == 3'd0) begin
               if (!rd_ok)            next_state = ERR;
               else if (idx == 2'd3)  next_state = DONE;
               else                   next_state = READ;
            end
         end
         DONE:    next_state = IDLE;
         ERR:     next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      busy          = (state != IDLE);
      done          = (state == DONE) || (state == ERR);
      mem.mem_en    = 1'b0;
      mem.mem_rd_wr = 1'b0;
      mem.mem_add   = 2'd0;
      mem.mem_data  = 8'h00;
      case (state)
         WRITE: begin
            mem.mem_en    = 1'b1;
            mem.mem_rd_wr = 1'b1;
            mem.mem_add   = idx;
            mem.mem_data  = shadow[idx];
         end
         READ: begin
            mem.mem_en  = 1'b1;
            mem.mem_add = idx;
         end
         default: ;
      endcase
   end

   // Flags are updated on the edge entering DONE/ERR so they are visible
   // together with the done pulse.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         idx       <= 2'd0;
         lat_cnt   <= 3'd0;
         shadow    <= '0;
         cfg_valid <= 1'b0;
         error     <= 1'b0;
         err_code  <= ERR_NONE;
         err_port  <= 2'd0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  shadow    <= addr_cfg;
                  cfg_valid <= 1'b0;
                  error     <= 1'b0;
                  err_code  <= ERR_NONE;
                  err_port  <= 2'd0;
               end
            end
            CHECK: begin
               idx <= 2'd0;
               if (dup) begin
                  error    <= 1'b1;
                  err_code <= ERR_DUP;
                  err_port <= dup_port;
               end
            end
            WRITE: idx <= (idx == 2'd3) ? 2'd0 : idx + 2'd1;
            READ:  lat_cnt <= 3'(RD_LAT - 1);
            WAIT: begin
               if (lat_cnt != 3'd0) begin
                  lat_cnt <= lat_cnt - 3'd1;
               end else if (!rd_ok) begin
                  error    <= 1'b1;
                  err_code <= ERR_MISMATCH;
                  err_port <= idx;
               end else if (idx != 2'd3) begin
                  idx <= idx + 2'd1;
               end else begin
                  cfg_valid <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_switch_cfg_ctrl.sv
// Directed bench for switch_cfg_ctrl: one instance with RD_LAT=1 and one with
// RD_LAT=3, each answered by a small echo memory with exact read latency.
module tb_switch_cfg_ctrl;
   import switch_cfg_pkg::*;

   logic        clock = 1'b0;
   logic        reset;
   logic        start_a, start_b;
   logic [31:0] addr_cfg;
   logic        corrupt_p1;
   logic        sel;

   logic       busy_a, done_a, cfg_valid_a, error_a;
   logic [1:0] err_code_a, err_port_a;
   logic       busy_b, done_b, cfg_valid_b, error_b;
   logic [1:0] err_code_b, err_port_b;

   int test_cnt = 0;
   int fail_cnt = 0;

   switch_cfg_ctrl_if mif_a ();
   switch_cfg_ctrl_if mif_b ();

   switch_cfg_ctrl #(.RD_LAT(1)) dut_a (
      .clock(clock), .reset(reset), .start(start_a), .addr_cfg(addr_cfg),
      .mem(mif_a), .busy(busy_a), .done(done_a), .cfg_valid(cfg_valid_a),
      .error(error_a), .err_code(err_code_a), .err_port(err_port_a));

   switch_cfg_ctrl #(.RD_LAT(3)) dut_b (
      .clock(clock), .reset(reset), .start(start_b), .addr_cfg(addr_cfg),
      .mem(mif_b), .busy(busy_b), .done(done_b), .cfg_valid(cfg_valid_b),
      .error(error_b), .err_code(err_code_b), .err_port(err_port_b));

   always #5 clock = ~clock;

   // Echo memories: read data appears exactly RD_LAT cycles after the command
   // and is zero otherwise, so a wrong sampling cycle shows up as a mismatch.
   logic [7:0] mem_a [4];
   logic [7:0] mem_b [4];
   logic [7:0] rd_a;
   logic [7:0] pipe_b [3];

   always @(posedge clock) begin
      rd_a <= 8'h00;
      if (mif_a.mem_en && mif_a.mem_rd_wr) mem_a[mif_a.mem_add] <= mif_a.mem_data;
      if (mif_a.mem_en && !mif_a.mem_rd_wr)
         rd_a <= (corrupt_p1 && mif_a.mem_add == 2'd1) ? 8'hFF : mem_a[mif_a.mem_add];
   end

   always @(posedge clock) begin
      pipe_b[0] <= 8'h00;
      pipe_b[1] <= pipe_b[0];
      pipe_b[2] <= pipe_b[1];
      if (mif_b.mem_en && mif_b.mem_rd_wr) mem_b[mif_b.mem_add] <= mif_b.mem_data;
      if (mif_b.mem_en && !mif_b.mem_rd_wr) pipe_b[0] <= mem_b[mif_b.mem_add];
   end

   assign mif_a.mem_rdata = rd_a;
   assign mif_b.mem_rdata = pipe_b[2];

   logic       o_en, o_rw, o_busy, o_done, o_valid, o_error;
   logic [1:0] o_add, o_code, o_port;
   logic [7:0] o_data;

   always_comb begin
      o_en    = sel ? mif_b.mem_en    : mif_a.mem_en;
      o_rw    = sel ? mif_b.mem_rd_wr : mif_a.mem_rd_wr;
      o_add   = sel ? mif_b.mem_add   : mif_a.mem_add;
      o_data  = sel ? mif_b.mem_data  : mif_a.mem_data;
      o_busy  = sel ? busy_b          : busy_a;
      o_done  = sel ? done_b          : done_a;
      o_valid = sel ? cfg_valid_b     : cfg_valid_a;
      o_error = sel ? error_b         : error_a;
      o_code  = sel ? err_code_b      : err_code_a;
      o_port  = sel ? err_port_b      : err_port_a;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      test_cnt++;
      assert (obs === exp) else begin
         fail_cnt++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check_idle_all_zero(input string tag);
      check({tag, " mem_en"},    32'(o_en),    32'd0);
      check({tag, " mem_rd_wr"}, 32'(o_rw),    32'd0);
      check({tag, " mem_add"},   32'(o_add),   32'd0);
      check({tag, " mem_data"},  32'(o_data),  32'd0);
      check({tag, " busy"},      32'(o_busy),  32'd0);
      check({tag, " done"},      32'(o_done),  32'd0);
      check({tag, " cfg_valid"}, 32'(o_valid), 32'd0);
      check({tag, " error"},     32'(o_error), 32'd0);
      check({tag, " err_code"},  32'(o_code),  32'd0);
      check({tag, " err_port"},  32'(o_port),  32'd0);
   endtask

   task automatic pulse_start(input logic s, input logic [31:0] cfg);
      sel      = s;
      addr_cfg = cfg;
      if (s) start_b = 1'b1; else start_a = 1'b1;
      tick();
      start_a = 1'b0;
      start_b = 1'b0;
   endtask

   // Expected bus activity for a passing run: writes on cycles 2-5, then one
   // read every 1+lat cycles from cycle 6, done on cycle 6+4*(1+lat).
   task automatic check_bus(input int c, input int lat, input logic [31:0] cfg, input int last);
      logic       exp_en, exp_rw;
      int         exp_idx;
      logic [7:0] exp_data;
      exp_en = 1'b0; exp_rw = 1'b0; exp_idx = 0; exp_data = 8'h00;
      if (c >= 2 && c <= 5) begin
         exp_en = 1'b1; exp_rw = 1'b1; exp_idx = c - 2;
         exp_data = cfg[8*exp_idx +: 8];
      end else if (c >= 6 && c < last && (c - 6) % (1 + lat) == 0) begin
         exp_en = 1'b1; exp_idx = (c - 6) / (1 + lat);
      end
      check($sformatf("mem_en c%0d", c), 32'(o_en), 32'(exp_en));
      if (exp_en) begin
         check($sformatf("mem_rd_wr c%0d", c), 32'(o_rw),   32'(exp_rw));
         check($sformatf("mem_add c%0d", c),   32'(o_add),  32'(exp_idx));
         check($sformatf("mem_data c%0d", c),  32'(o_data), 32'(exp_data));
      end
   endtask

   task automatic run_valid(input logic s, input int lat, input logic [31:0] cfg);
      int last;
      last = 6 + 4 * (1 + lat);
      pulse_start(s, cfg);
      for (int c = 1; c <= last; c++) begin
         if (c == 1) check("cfg_valid drop c1", 32'(o_valid), 32'd0);
         check_bus(c, lat, cfg, last);
         check($sformatf("busy c%0d", c), 32'(o_busy), 32'd1);
         check($sformatf("done c%0d", c), 32'(o_done), 32'(c == last));
         if (c == last) begin
            check("pass cfg_valid", 32'(o_valid), 32'd1);
            check("pass error",     32'(o_error), 32'd0);
            check("pass err_code",  32'(o_code),  32'd0);
            if (s) start_b = 1'b1; else start_a = 1'b1;
         end
         tick();
      end
      start_a = 1'b0;
      start_b = 1'b0;
      check("start at DONE edge ignored", 32'(o_busy), 32'd0);
      check("cfg_valid held", 32'(o_valid), 32'd1);
      check("done after pass", 32'(o_done), 32'd0);
   endtask

   task automatic run_dup(input logic [31:0] cfg, input logic [1:0] exp_port);
      pulse_start(1'b0, cfg);
      check("dup c1 busy",   32'(o_busy), 32'd1);
      check("dup c1 done",   32'(o_done), 32'd0);
      check("dup c1 mem_en", 32'(o_en),   32'd0);
      tick();
      check("dup c2 done",      32'(o_done),  32'd1);
      check("dup c2 error",     32'(o_error), 32'd1);
      check("dup c2 err_code",  32'(o_code),  32'(ERR_DUP));
      check("dup c2 err_port",  32'(o_port),  32'(exp_port));
      check("dup c2 cfg_valid", 32'(o_valid), 32'd0);
      check("dup c2 mem_en",    32'(o_en),    32'd0);
      tick();
      check("dup c3 busy",         32'(o_busy),  32'd0);
      check("dup c3 error sticky", 32'(o_error), 32'd1);
      check("dup c3 mem_en",       32'(o_en),    32'd0);
   endtask

   initial begin
      reset = 1'b0; start_a = 1'b0; start_b = 1'b0;
      addr_cfg = 32'h0; corrupt_p1 = 1'b0; sel = 1'b0;

      // Reset held three cycles, then released with no start.
      for (int c = 0; c < 3; c++) begin
         tick();
         sel = 1'b0; #0 check_idle_all_zero($sformatf("rst a c%0d", c));
         sel = 1'b1; #0 check_idle_all_zero($sformatf("rst b c%0d", c));
      end
      reset = 1'b1;
      for (int c = 0; c < 2; c++) begin
         tick();
         sel = 1'b0; #0 check_idle_all_zero($sformatf("post-rst a c%0d", c));
         sel = 1'b1; #0 check_idle_all_zero($sformatf("post-rst b c%0d", c));
      end

      run_valid(1'b0, 1, 32'h40302010);

      run_dup(32'h11552255, 2'd2);
      run_dup(32'h55225511, 2'd3);
      run_dup(32'h00000000, 2'd1);

      // Port-1 read-back corrupted: error raised after the second read.
      corrupt_p1 = 1'b1;
      pulse_start(1'b0, 32'h44332211);
      for (int c = 1; c < 10; c++) begin
         check_bus(c, 1, 32'h44332211, 14);
         check($sformatf("mm busy c%0d", c), 32'(o_busy), 32'd1);
         tick();
      end
      check("mm done",      32'(o_done),  32'd1);
      check("mm error",     32'(o_error), 32'd1);
      check("mm err_code",  32'(o_code),  32'(ERR_MISMATCH));
      check("mm err_port",  32'(o_port),  32'd1);
      check("mm cfg_valid", 32'(o_valid), 32'd0);
      check("mm c10 mem_en", 32'(o_en),   32'd0);
      tick();
      check("mm no port2 read", 32'(o_en),   32'd0);
      check("mm idle",          32'(o_busy), 32'd0);
      corrupt_p1 = 1'b0;

      // Re-program, ignore a start mid-sequence, then reset asynchronously.
      run_valid(1'b0, 1, 32'h0D0C0B0A);
      pulse_start(1'b0, 32'h77665544);
      check("rst-seq cfg_valid drop", 32'(o_valid), 32'd0);
      for (int c = 1; c < 5; c++) tick();
      addr_cfg = 32'h01010101;
      start_a  = 1'b1;
      tick();
      start_a  = 1'b0;
      check("busy start ignored c6 mem_en",  32'(o_en),  32'd1);
      check("busy start ignored c6 mem_add", 32'(o_add), 32'd0);
      tick();
      tick();
      check("shadow kept c8 mem_add", 32'(o_add),   32'd1);
      check("shadow kept c8 error",   32'(o_error), 32'd0);
      reset = 1'b0;
      #1;
      check_idle_all_zero("async rst");
      tick();
      reset = 1'b1;
      tick();

      run_valid(1'b1, 3, 32'hA5C33C5A);

      $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
      $finish;
   end

endmodule
